// File: rtl/load_store_unit_if.sv
// Request/response and byte-memory bus between a requester and the load/store unit.
// The master side drives requests and returns the memory read byte.
interface load_store_unit_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;

    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sign_ext;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          misalign;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [BW-1:0] mem_rdata;

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_rdata,
        input  busy, done, misalign, rdata, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_rdata,
        output busy, done, misalign, rdata, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/load_store_unit.sv
// Serialises byte/half/word loads and stores onto a byte-wide memory, big-endian,
// one byte per cycle, with optional misalignment faulting.
module load_store_unit #(
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 2;

    typedef enum logic [1:0] {IDLE, XFER, FAULT, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n, last, last_n;
    logic [AW-1:0] addr_l, addr_n;
    logic [DW-1:0] wdata_l, wdata_n;
    logic [1:0]    size_l, size_n;
    logic          we_l, we_n, sext_l, sext_n;
    logic [DW-1:0] acc, acc_n, rdata_n;
    logic          busy_n, done_n, misalign_n, mem_we_n, mem_re_n;
    logic [AW-1:0] mem_addr_n;
    logic [BW-1:0] mem_wdata_n;
    logic          req_half, req_word, misaligned;
    logic [DW-1:0] loaded;

    // Request decode and the shifted-in load value for this cycle
    always_comb begin
        req_word   = bus.size[1];
        req_half   = (bus.size == 2'b01);
        misaligned = (req_half && bus.addr[0]) || (req_word && (bus.addr[1:0] != 2'b00));
        loaded     = {acc[DW-BW-1:0], bus.mem_rdata};
    end

    // Next state, datapath and next-cycle outputs; outputs are registered from these
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        last_n      = last;
        addr_n      = addr_l;
        size_n      = size_l;
        we_n        = we_l;
        sext_n      = sext_l;
        wdata_n     = wdata_l;
        acc_n       = acc;
        rdata_n     = bus.rdata;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        misalign_n  = 1'b0;
        mem_addr_n  = '0;
        mem_wdata_n = '0;
        mem_we_n    = 1'b0;
        mem_re_n    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    addr_n  = bus.addr;
                    size_n  = bus.size;
                    we_n    = bus.we;
                    sext_n  = bus.sign_ext;
                    wdata_n = bus.wdata;
                    idx_n   = '0;
                    acc_n   = '0;
                    last_n  = req_word ? IW'(3) : (req_half ? IW'(1) : IW'(0));
                    state_n = ((ALIGN_CHECK != 0) && misaligned) ? FAULT : XFER;
                end
            end
            XFER: begin
                if (!we_l) acc_n = loaded;
                if (idx == last) begin
                    state_n = DONE;
                    // Extension uses the just-completed accumulator value
                    if (!we_l) begin
                        if (size_l[1])
                            rdata_n = loaded;
                        else if (size_l == 2'b01)
                            rdata_n = {{(DW-16){sext_l & loaded[15]}}, loaded[15:0]};
                        else
                            rdata_n = {{(DW-8){sext_l & loaded[7]}}, loaded[7:0]};
                    end
                end else begin
                    idx_n = idx + IW'(1);
                end
            end
            FAULT:   state_n = IDLE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n     = (state_n != IDLE);
        done_n     = (state_n == DONE) || (state_n == FAULT);
        misalign_n = (state_n == FAULT);

        if (state_n == XFER) begin
            mem_addr_n = addr_n + AW'(idx_n);
            mem_we_n   = we_n;
            mem_re_n   = !we_n;
            if (we_n) begin
                if (size_n[1]) begin
                    case (idx_n)
                        2'd0:    mem_wdata_n = wdata_n[31:24];
                        2'd1:    mem_wdata_n = wdata_n[23:16];
                        2'd2:    mem_wdata_n = wdata_n[15:8];
                        default: mem_wdata_n = wdata_n[7:0];
                    endcase
                end else if (size_n == 2'b01) begin
                    mem_wdata_n = (idx_n == IW'(0)) ? wdata_n[15:8] : wdata_n[7:0];
                end else begin
                    mem_wdata_n = wdata_n[7:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            last          <= '0;
            addr_l        <= '0;
            size_l        <= '0;
            we_l          <= 1'b0;
            sext_l        <= 1'b0;
            wdata_l       <= '0;
            acc           <= '0;
            bus.rdata     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.misalign  <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            last          <= last_n;
            addr_l        <= addr_n;
            size_l        <= size_n;
            we_l          <= we_n;
            sext_l        <= sext_n;
            wdata_l       <= wdata_n;
            acc           <= acc_n;
            bus.rdata     <= rdata_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
            bus.misalign  <= misalign_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
            bus.mem_we    <= mem_we_n;
            bus.mem_re    <= mem_re_n;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (alignment faulting on/off)
// with byte-wide memory models and a log of every memory strobe.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    logic preload;
    always #5 clk = ~clk;

    load_store_unit_if ia();
    load_store_unit_if ib();

    load_store_unit #(.ALIGN_CHECK(1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    load_store_unit #(.ALIGN_CHECK(0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    assign ia.mem_rdata = mem_a[ia.mem_addr[7:0]];
    assign ib.mem_rdata = mem_b[ib.mem_addr[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {logic fault; logic [31:0] rd; int lat; int t;} exp_t;
    typedef struct {logic we; logic [31:0] a; logic [7:0] d; int c;} acc_t;
    exp_t qa[$];
    exp_t qb[$];
    acc_t la[$];
    acc_t lb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory models plus a log of every strobed byte (address, data, cycle)
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
            mem_a[8'h20] <= 8'h80; mem_a[8'h21] <= 8'h01;
            mem_a[8'h22] <= 8'hFF; mem_a[8'h23] <= 8'h7E;
            mem_a[8'h40] <= 8'hEE; mem_a[8'h41] <= 8'hEE;
            mem_a[8'h42] <= 8'hEE; mem_a[8'h43] <= 8'hEE;
            mem_b[8'h21] <= 8'h01; mem_b[8'h22] <= 8'hFF;
            mem_b[8'h23] <= 8'h7E; mem_b[8'h24] <= 8'h5A;
        end else begin
            if (ia.mem_we) mem_a[ia.mem_addr[7:0]] <= ia.mem_wdata;
            if (ib.mem_we) mem_b[ib.mem_addr[7:0]] <= ib.mem_wdata;
        end
        if (ia.mem_we || ia.mem_re)
            la.push_back('{ia.mem_we, ia.mem_addr, ia.mem_we ? ia.mem_wdata : ia.mem_rdata, cyc});
        if (ib.mem_we || ib.mem_re)
            lb.push_back('{ib.mem_we, ib.mem_addr, ib.mem_we ? ib.mem_wdata : ib.mem_rdata, cyc});
    end

    // Monitor: every done pops one expected completion; idle bus must be all zero
    task automatic mon(input bit b);
        logic d, m, we, re;
        logic [31:0] rd, ma;
        logic [7:0] wd;
        exp_t e;
        string p;
        int n;
        p = b ? "B" : "A";
        if (b) begin
            d = ib.done; m = ib.misalign; we = ib.mem_we; re = ib.mem_re;
            rd = ib.rdata; ma = ib.mem_addr; wd = ib.mem_wdata; n = qb.size();
        end else begin
            d = ia.done; m = ia.misalign; we = ia.mem_we; re = ia.mem_re;
            rd = ia.rdata; ma = ia.mem_addr; wd = ia.mem_wdata; n = qa.size();
        end
        if (d) begin
            if (n == 0) begin
                check({p, "_unexpected_done"}, 64'(1), 64'(0));
            end else begin
                if (b) e = qb.pop_front(); else e = qa.pop_front();
                check({p, "_misalign"}, 64'(m), 64'(e.fault));
                check({p, "_rdata"}, 64'(rd), 64'(e.rd));
                check({p, "_latency"}, 64'(cyc + 1 - e.t), 64'(e.lat));
            end
        end
        if (!we && !re)
            check({p, "_idle_bus"}, 64'({ma, wd, m & ~d, we & re}), 64'(0));
    endtask

    always @(negedge clk) begin
        if (!reset && !preload) begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    task automatic issue(input bit b, input bit w, input logic [1:0] sz, input bit se,
                         input logic [31:0] a, input logic [31:0] wd, input bit flt,
                         input logic [31:0] rd, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        if (b) begin
            ib.req = 1'b1; ib.we = w; ib.size = sz; ib.sign_ext = se; ib.addr = a; ib.wdata = wd;
        end else begin
            ia.req = 1'b1; ia.we = w; ia.size = sz; ia.sign_ext = se; ia.addr = a; ia.wdata = wd;
        end
        @(posedge clk);
        #1;
        ia.req = 1'b0;
        ib.req = 1'b0;
        e = '{flt, rd, lat, cyc};
        if (push) begin
            if (b) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    task automatic wait_idle(input bit b);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b && !ib.busy && qb.size() == 0) return;
            if (!b && !ia.busy && qa.size() == 0) return;
        end
        check(b ? "B_timeout" : "A_timeout", 64'(1), 64'(0));
    endtask

    // Compare the strobe log with n bytes from a0 upward, bytes given MSB-first
    task automatic check_log(input bit b, input int n, input bit w, input logic [31:0] a0,
                             input logic [31:0] bytes);
        acc_t q[$];
        logic [7:0] eb;
        string p;
        p = b ? "B" : "A";
        if (b) begin q = lb; lb.delete(); end else begin q = la; la.delete(); end
        check({p, "_strobe_count"}, 64'(q.size()), 64'(n));
        for (int j = 0; j < n && j < q.size(); j++) begin
            eb = 8'(bytes >> (8 * (n - 1 - j)));
            check({p, "_strobe"}, 64'({q[j].we, q[j].a, q[j].d}), 64'({w, a0 + 32'(j), eb}));
            if (j > 0) check({p, "_strobe_cycle"}, 64'(q[j].c - q[j-1].c), 64'(1));
        end
    endtask

    initial begin
        ia.req = 0; ia.we = 0; ia.size = 0; ia.sign_ext = 0; ia.addr = 0; ia.wdata = 0;
        ib.req = 0; ib.we = 0; ib.size = 0; ib.sign_ext = 0; ib.addr = 0; ib.wdata = 0;
        reset = 1'b1;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        check("A_reset_ctl", 64'({ia.busy, ia.done, ia.misalign, ia.mem_we, ia.mem_re}), 64'(0));
        check("A_reset_rdata", 64'(ia.rdata), 64'(0));
        check("B_reset_ctl", 64'({ib.busy, ib.done, ib.misalign, ib.mem_we, ib.mem_re}), 64'(0));
        reset = 1'b0;

        // store word, loads with both extensions, halfword cases
        issue(0, 1, 2'b10, 0, 32'h10, 32'hA1B2C3D4, 0, 32'h0, 5, 1);
        wait_idle(0); check_log(0, 4, 1, 32'h10, 32'hA1B2C3D4);
        issue(0, 0, 2'b00, 1, 32'h20, 32'h0, 0, 32'hFFFFFF80, 2, 1);
        wait_idle(0); check_log(0, 1, 0, 32'h20, 32'h80);
        issue(0, 0, 2'b00, 0, 32'h20, 32'h0, 0, 32'h00000080, 2, 1);
        wait_idle(0); check_log(0, 1, 0, 32'h20, 32'h80);
        issue(0, 0, 2'b10, 1, 32'h20, 32'h0, 0, 32'h8001FF7E, 5, 1);
        wait_idle(0); check_log(0, 4, 0, 32'h20, 32'h8001FF7E);
        issue(0, 0, 2'b01, 1, 32'h22, 32'h0, 0, 32'hFFFFFF7E, 3, 1);
        wait_idle(0); check_log(0, 2, 0, 32'h22, 32'hFF7E);
        issue(0, 1, 2'b01, 0, 32'h30, 32'hDEAD1234, 0, 32'hFFFFFF7E, 3, 1);
        wait_idle(0); check_log(0, 2, 1, 32'h30, 32'h1234);
        issue(0, 0, 2'b01, 0, 32'h20, 32'h0, 0, 32'h00008001, 3, 1);
        wait_idle(0); check_log(0, 2, 0, 32'h20, 32'h8001);
        issue(0, 1, 2'b00, 1, 32'h50, 32'hFFFFFFAB, 0, 32'h00008001, 2, 1);
        wait_idle(0); check_log(0, 1, 1, 32'h50, 32'hAB);
        issue(0, 0, 2'b11, 1, 32'h20, 32'h0, 0, 32'h8001FF7E, 5, 1);
        wait_idle(0); check_log(0, 4, 0, 32'h20, 32'h8001FF7E);

        // misaligned requests fault on A, proceed bytewise on B (including address wrap)
        issue(0, 0, 2'b10, 1, 32'h21, 32'h0, 1, 32'h8001FF7E, 1, 1);
        wait_idle(0); check_log(0, 0, 0, 32'h0, 32'h0);
        issue(0, 1, 2'b01, 0, 32'h33, 32'h5555, 1, 32'h8001FF7E, 1, 1);
        wait_idle(0); check_log(0, 0, 0, 32'h0, 32'h0);
        check("A_mem_33_untouched", 64'({mem_a[8'h33], mem_a[8'h34]}), 64'(0));
        issue(1, 0, 2'b10, 0, 32'h21, 32'h0, 0, 32'h01FF7E5A, 5, 1);
        wait_idle(1); check_log(1, 4, 0, 32'h21, 32'h01FF7E5A);
        issue(1, 1, 2'b01, 0, 32'hFFFFFFFF, 32'h0000BEEF, 0, 32'h01FF7E5A, 3, 1);
        wait_idle(1); check_log(1, 2, 1, 32'hFFFFFFFF, 32'hBEEF);

        // requests while busy are dropped
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h8001FF7E, 5, 1);
        ia.req = 1'b1; ia.we = 1'b1; ia.size = 2'b00; ia.addr = 32'h60; ia.wdata = 32'h55;
        repeat (4) @(posedge clk);
        #1 ia.req = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        check_log(0, 4, 0, 32'h20, 32'h8001FF7E);

        // reset in the middle of a word store
        issue(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 32'h0, 5, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("A_async_reset_ctl", 64'({ia.busy, ia.done, ia.mem_we, ia.mem_re}), 64'(0));
        check("A_async_reset_rdata", 64'(ia.rdata), 64'(0));
        check("B_async_reset_rdata", 64'(ib.rdata), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        check("A_mem_40_41", 64'({mem_a[8'h40], mem_a[8'h41]}), 64'(16'hCAFE));
        check("A_mem_42_43", 64'({mem_a[8'h42], mem_a[8'h43]}), 64'(16'hEEEE));
        check_log(0, 2, 1, 32'h40, 32'hCAFE);
        issue(0, 0, 2'b00, 0, 32'h41, 32'h0, 0, 32'h000000FE, 2, 1);
        wait_idle(0); check_log(0, 1, 0, 32'h41, 32'hFE);

        check("A_queue_empty", 64'(qa.size()), 64'(0));
        check("B_queue_empty", 64'(qb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ALIGN_CHECK, default 1, 1 = misaligned half/word requests fault without memory access; 0 = misaligned requests proceed bytewise.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  1  request strobe; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-007 sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  input  32  byte address of the access.
REQ-009 wdata  input  32  store data, right-justified for byte/half.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 misalign  output  1  one-cycle fault pulse, coincident with done.
REQ-013 rdata  output  32  extended load result; holds until next completed load.
REQ-014 mem_addr  output  32  byte address to byte-wide data memory.
REQ-015 mem_wdata  output  8  byte to write.
REQ-016 mem_we  output  1  byte write strobe, written on rising clk.
REQ-017 mem_re  output  1  byte read enable.
REQ-018 mem_rdata  input  8  combinational read byte at mem_addr.

Function
REQ-019 States: IDLE, XFER, FAULT, DONE; reset state IDLE.
REQ-020 IDLE with req=1: latch addr, size, we, wdata, sign_ext; byte count N = 1/2/4; clear byte index i to 0.
REQ-021 Misaligned = (half and addr[0]=1) or (word and addr[1:0]!=0); with ALIGN_CHECK=1 go IDLE->FAULT, otherwise IDLE->XFER.
REQ-022 XFER: one byte per cycle; mem_addr = latched addr + i, mod 2^32 (wraps 0xFFFFFFFF->0x00000000).
REQ-023 Byte order big-endian: i=0 is the most significant byte of the access.
REQ-024 Store byte i: word wdata[31-8i:24-8i]; half wdata[15-8i:8-8i]; byte wdata[7:0]; mem_we=1, mem_re=0.
REQ-025 Load byte i: mem_re=1, mem_we=0; accumulator <= {accumulator[23:0], mem_rdata} at clock edge.
REQ-026 XFER -> DONE after byte i=N-1; otherwise i increments.
REQ-027 DONE: done=1 for exactly one cycle; on a load, rdata updates at entry to DONE with the extended value (byte: bit 7, half: bit 15 replicated if sign_ext, else zeros); next state IDLE.
REQ-028 FAULT: done=1 and misalign=1 for one cycle, no mem_we/mem_re, rdata unchanged; next state IDLE.
REQ-029 Stores never modify rdata.
REQ-030 mem_we, mem_re = 0 and mem_addr, mem_wdata = 0 outside XFER.
REQ-031 req while busy=1 (including DONE/FAULT) is ignored, not queued; a new request is accepted no earlier than the cycle after done.
REQ-032 Latency from req-sampling edge T: byte done at T+2, half T+3, word T+5, fault T+1 (done visible the cycle after the edge).
REQ-033 Inputs other than req are don't-care outside the IDLE accept cycle.

Reset
REQ-034 reset=1 asynchronously forces IDLE, i=0, accumulator=0, rdata=0, and all outputs 0, including mid-XFER; mem_we drops immediately, so a store interrupted by reset leaves earlier bytes written and later bytes untouched.
REQ-035 First request accepted on the first rising edge with reset=0 and req=1.

Verification
REQ-036 Store word 0xA1B2C3D4 to addr 0x10 -> bytes 0x10..0x13 = A1,B2,C3,D4 on four consecutive cycles; done at T+5; rdata unchanged.
REQ-037 Memory 0x20..0x23 = 80,01,FF,7E; load byte 0x20, sign_ext=1 -> rdata 0xFFFFFF80; sign_ext=0 -> 0x00000080; load word 0x20 -> 0x8001FF7E at T+5.
REQ-038 Load half addr 0x22, sign_ext=1 -> 0xFFFFFF7E; store half 0x1234 to 0x30 -> 0x30=12, 0x31=34, done at T+3.
REQ-039 ALIGN_CHECK=1, load word addr 0x21 -> done=misalign=1 at T+1, no mem strobes, rdata holds previous value; ALIGN_CHECK=0 same request -> reads 0x21..0x24.
REQ-040 Assert reset after second byte of word store to 0x40 -> 0x40,0x41 written, 0x42,0x43 unchanged, busy=0 immediately; req during busy is ignored and produces no extra done.
